// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared types and defaults for the I2C sensor configuration sequencer.
package i2c_cfg_sequencer_pkg;

    // Sequencer states; RETRY_GAP holds i2c_req low for one cycle between NACKed attempts.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_WRITE,
        ST_RETRY_GAP,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    localparam int unsigned DEF_REG_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam logic [15:0] DEF_DELAY_TAG  = 16'hFFFF;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_cfg_ms_timer.sv
// Millisecond countdown: load N ms, prescaler restarts on load, expired_c is high
// for exactly one cycle at the end of the wait (immediately for N == 0).
module i2c_cfg_ms_timer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 24_000_000,
    parameter int unsigned MS_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [MS_W-1:0] load_ms,
    output logic            expired_c
);

    localparam int unsigned TICK     = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned PRE_W    = width_for(TICK);
    // The load cycle itself counts as the first prescaler cycle.
    localparam int unsigned LOAD_PRE = (TICK > 1) ? 1 : 0;

    logic             armed_q, armed_d;
    logic [MS_W-1:0]  ms_left_q, ms_left_d;
    logic [PRE_W-1:0] pre_q, pre_d;

    // Expire on the last prescaler cycle of the last millisecond.
    assign expired_c = armed_q &&
                       ((ms_left_q == '0) ||
                        ((ms_left_q == MS_W'(1)) && (pre_q == PRE_W'(TICK - 1))));

    // Prescaler and millisecond countdown next-state.
    always_comb begin
        armed_d   = armed_q;
        ms_left_d = ms_left_q;
        pre_d     = pre_q;
        if (load) begin
            armed_d   = 1'b1;
            ms_left_d = load_ms;
            pre_d     = PRE_W'(LOAD_PRE);
        end else if (armed_q) begin
            if (expired_c) begin
                armed_d = 1'b0;
            end else if (pre_q == PRE_W'(TICK - 1)) begin
                pre_d     = '0;
                ms_left_d = ms_left_q - MS_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q   <= 1'b0;
            ms_left_q <= '0;
            pre_q     <= '0;
        end else begin
            armed_q   <= armed_d;
            ms_left_q <= ms_left_d;
            pre_q     <= pre_d;
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a {reg_addr, data} config LUT and issues one I2C register write per entry,
// with in-table delays, NACK retry, profile select and done/error status.
module i2c_cfg_sequencer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 24_000_000,
    parameter int unsigned REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned INDEX_W       = 9,
    parameter int unsigned MODE_W        = 2,
    parameter int unsigned INIT_DELAY_MS = 20,
    parameter logic [REG_ADDR_W-1:0] DELAY_TAG = REG_ADDR_W'(DEF_DELAY_TAG),
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic [MODE_W-1:0]            cfg_mode,
    output logic [MODE_W-1:0]            lut_mode,
    output logic [INDEX_W-1:0]           lut_index,
    input  logic [REG_ADDR_W+DATA_W-1:0] lut_data,
    input  logic [INDEX_W-1:0]           lut_size,
    output logic                         i2c_req,
    output logic [REG_ADDR_W-1:0]        i2c_addr,
    output logic [DATA_W-1:0]            i2c_wdata,
    input  logic                         i2c_done,
    input  logic                         i2c_nack,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_error,
    output logic [INDEX_W-1:0]           err_index
);

    localparam int unsigned LUT_W     = REG_ADDR_W + DATA_W;
    localparam int unsigned MS_W      = (DATA_W > 16) ? DATA_W : 16;
    localparam int unsigned RETRY_W   = width_for(MAX_RETRY);
    localparam int unsigned IDX_EXT_W = INDEX_W + 1;

    cfg_state_e            state_q, state_d;
    logic [MODE_W-1:0]     lut_mode_q, lut_mode_d;
    logic [INDEX_W-1:0]    lut_index_q, lut_index_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [INDEX_W-1:0]    err_index_q, err_index_d;

    logic                  tmr_load_c;
    logic [MS_W-1:0]       tmr_ms_c;
    logic                  tmr_expired_c;
    logic                  advance_c;
    logic [IDX_EXT_W-1:0]  next_index_c;
    logic [REG_ADDR_W-1:0] lut_addr_c;
    logic [DATA_W-1:0]     lut_wdata_c;

    assign lut_addr_c  = lut_data[LUT_W-1 -: REG_ADDR_W];
    assign lut_wdata_c = lut_data[DATA_W-1:0];

    i2c_cfg_ms_timer #(
        .CLK_FREQ (CLK_FREQ),
        .MS_W     (MS_W)
    ) u_ms_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load_c),
        .load_ms   (tmr_ms_c),
        .expired_c (tmr_expired_c)
    );

    // Next-state and registered-output logic for the LUT walk.
    always_comb begin
        state_d      = state_q;
        lut_mode_d   = lut_mode_q;
        lut_index_d  = lut_index_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        retry_d      = retry_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        tmr_load_c   = 1'b0;
        tmr_ms_c     = '0;
        advance_c    = 1'b0;
        next_index_c = {1'b0, lut_index_q} + IDX_EXT_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start) begin
                    lut_mode_d  = cfg_mode;
                    lut_index_d = '0;
                    retry_d     = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    tmr_load_c  = 1'b1;
                    tmr_ms_c    = MS_W'(INIT_DELAY_MS);
                    state_d     = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (tmr_expired_c) begin
                    if (lut_size == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                addr_d  = lut_addr_c;
                wdata_d = lut_wdata_c;
                if (lut_addr_c == DELAY_TAG) begin
                    tmr_load_c = 1'b1;
                    tmr_ms_c   = MS_W'(lut_wdata_c);
                    state_d    = ST_DELAY;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        advance_c = 1'b1;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RETRY_GAP;
                    end else begin
                        busy_d      = 1'b0;
                        error_d     = 1'b1;
                        err_index_d = lut_index_q;
                        state_d     = ST_ERROR;
                    end
                end
            end
            ST_RETRY_GAP: begin
                state_d = ST_WRITE;
            end
            ST_DELAY: begin
                if (tmr_expired_c) begin
                    advance_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Step to the next entry; the extra index bit keeps a full table from wrapping.
        if (advance_c) begin
            retry_d = '0;
            if (next_index_c == {1'b0, lut_size}) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                lut_index_d = next_index_c[INDEX_W-1:0];
                state_d     = ST_FETCH;
            end
        end

        // Request is high exactly while the FSM sits in WRITE.
        req_d = (state_d == ST_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lut_mode_q  <= '0;
            lut_index_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            retry_q     <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            lut_mode_q  <= lut_mode_d;
            lut_index_q <= lut_index_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    assign lut_mode  = lut_mode_q;
    assign lut_index = lut_index_q;
    assign i2c_req   = req_q;
    assign i2c_addr  = addr_q;
    assign i2c_wdata = wdata_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: 10 cycles per ms, 2 ms power-up wait.
module tb_i2c_cfg_sequencer;

    localparam int unsigned CLK_FREQ      = 10_000;
    localparam int unsigned INIT_DELAY_MS = 2;
    localparam int unsigned MAX_RETRY     = 3;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [1:0]  cfg_mode;
    logic [1:0]  lut_mode;
    logic [8:0]  lut_index;
    logic [23:0] lut_data;
    logic [8:0]  lut_size;
    logic        i2c_req;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [8:0]  err_index;

    int checks   = 0;
    int failures = 0;

    // Two profiles; the LUT mux follows lut_mode like the external profile mux.
    logic [23:0] lut0 [0:7];
    logic [23:0] lut1 [0:7];
    logic [8:0]  size0;
    logic [8:0]  size1;

    // Responder NACK policy: nack_left < 0 means NACK forever.
    logic [15:0] nack_addr;
    int          nack_left;

    // Scoreboard of expected {addr, data} writes, in order.
    logic [23:0] exp_q [$];
    int          req_count = 0;
    int          low_cnt   = 0;
    int          last_gap  = 0;

    i2c_cfg_sequencer #(
        .CLK_FREQ      (CLK_FREQ),
        .INIT_DELAY_MS (INIT_DELAY_MS),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_mode  (cfg_mode),
        .lut_mode  (lut_mode),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .lut_size  (lut_size),
        .i2c_req   (i2c_req),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .err_index (err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational LUT profile mux.
    always_comb begin
        lut_data = '0;
        if (lut_index < 9'd8) begin
            if (lut_mode == 2'd1) lut_data = lut1[lut_index[2:0]];
            else                  lut_data = lut0[lut_index[2:0]];
        end
        lut_size = (lut_mode == 2'd1) ? size1 : size0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic pulse_start(input logic [1:0] mode);
        @(negedge clk);
        cfg_mode  = mode;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_mode  = 2'd0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (cfg_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(cfg_busy), 64'(0));
    endtask

    // I2C master model: completes each request 5 cycles after it rises.
    initial begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i2c_req && !rst) begin
                repeat (4) @(posedge clk);
                #1;
                i2c_done = 1'b1;
                i2c_nack = (nack_left != 0) && (i2c_addr == nack_addr);
                if (i2c_nack && nack_left > 0) nack_left--;
                @(posedge clk);
                #1;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Monitor: every new request is popped against the scoreboard.
    initial begin
        logic        req_prev;
        logic [23:0] e;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                if (i2c_req && !req_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_req got=%h_%h required=none", i2c_addr, i2c_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({i2c_addr, i2c_wdata} !== e) begin
                            failures++;
                            $display("FAIL write_order got=%h_%h required=%h_%h",
                                     i2c_addr, i2c_wdata, e[23:8], e[7:0]);
                        end
                    end
                    last_gap = low_cnt;
                    low_cnt  = 0;
                    req_count++;
                end else if (!i2c_req) begin
                    low_cnt++;
                end
                req_prev = i2c_req;
            end
        end
    end

    initial begin
        int n;
        int base;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_mode  = 2'd0;
        nack_addr = 16'h0000;
        nack_left = 0;
        for (int i = 0; i < 8; i++) begin
            lut0[i] = '0;
            lut1[i] = '0;
        end
        lut0[0] = 24'h3103_11;
        lut0[1] = 24'h3008_82;
        lut0[2] = 24'h3037_13;
        lut1[0] = 24'h4202_01;
        lut1[1] = 24'h4203_02;
        size0   = 9'd3;
        size1   = 9'd2;

        repeat (3) @(negedge clk);
        check("reset_outputs", {i2c_req, cfg_busy, cfg_done, cfg_error, lut_mode, lut_index,
                                err_index, i2c_addr, i2c_wdata}, 64'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("no_auto_start", {62'(0), cfg_busy, i2c_req}, 64'(0));

        // 3 writes in order; first request 20+-1 cycles after the start edge.
        exp_q.push_back(24'h3103_11);
        exp_q.push_back(24'h3008_82);
        exp_q.push_back(24'h3037_13);
        base = req_count;
        @(negedge clk);
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        n = 0;
        while (!i2c_req && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_range("first_req_latency", n, 19, 21);
        // A start while busy must not restart or switch profile.
        pulse_start(2'd1);
        wait_idle("t1_idle");
        check("t1_done", {cfg_done, cfg_error}, 64'h2);
        check("t1_mode_kept", 64'(lut_mode), 64'(0));
        check("t1_req_count", 64'(req_count - base), 64'(3));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // Delay entry of 5 ms between two writes.
        lut0[1] = 24'hFFFF_05;
        lut0[2] = 24'h3008_82;
        exp_q.push_back(24'h3103_11);
        exp_q.push_back(24'h3008_82);
        base = req_count;
        pulse_start(2'd0);
        wait_idle("t2_idle");
        // 50-cycle wait plus fetch/decode of the delay entry and of the next write.
        check_range("delay_gap", last_gap, 52, 54);
        check("t2_req_count", 64'(req_count - base), 64'(2));
        check("t2_done", 64'(cfg_done), 64'(1));

        // Two NACKs on entry 1, then ACK.
        lut0[1] = 24'h3008_82;
        lut0[2] = 24'h3037_13;
        nack_addr = 16'h3008;
        nack_left = 2;
        exp_q.push_back(24'h3103_11);
        exp_q.push_back(24'h3008_82);
        exp_q.push_back(24'h3008_82);
        exp_q.push_back(24'h3008_82);
        exp_q.push_back(24'h3037_13);
        pulse_start(2'd0);
        wait_idle("t3_idle");
        check("t3_done_no_error", {cfg_done, cfg_error}, 64'h2);
        check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

        // Permanent NACK on entry 2: initial attempt plus 3 retries, then ERROR.
        nack_addr = 16'h3037;
        nack_left = -1;
        exp_q.push_back(24'h3103_11);
        exp_q.push_back(24'h3008_82);
        for (int i = 0; i < 4; i++) exp_q.push_back(24'h3037_13);
        base = req_count;
        pulse_start(2'd0);
        wait_idle("t4_idle");
        repeat (20) @(negedge clk);
        check("t4_error_flags", {cfg_error, cfg_done, cfg_busy, i2c_req}, 64'h8);
        check("t4_err_index", 64'(err_index), 64'(2));
        check("t4_req_count", 64'(req_count - base), 64'(6));
        nack_left = 0;

        // Empty profile: done after init wait with no requests; clears previous error.
        size0 = 9'd0;
        base  = req_count;
        pulse_start(2'd0);
        check("t5_busy", 64'(cfg_busy), 64'(1));
        check("t5_error_cleared", {cfg_error, err_index}, 64'(0));
        wait_idle("t5_idle");
        check("t5_done", 64'(cfg_done), 64'(1));
        check("t5_no_req", 64'(req_count - base), 64'(0));

        // Async reset in the middle of a write, then restart on profile 1.
        size0 = 9'd3;
        exp_q.push_back(24'h3103_11);
        pulse_start(2'd0);
        n = 0;
        while (!i2c_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_req_seen", 64'(i2c_req), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_drop", 64'(i2c_req), 64'(0));
        check("t6_reset_outputs", {i2c_req, cfg_busy, cfg_done, cfg_error, lut_mode, lut_index,
                                   err_index, i2c_addr, i2c_wdata}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(24'h4202_01);
        exp_q.push_back(24'h4203_02);
        pulse_start(2'd1);
        check("t6_mode_latched", 64'(lut_mode), 64'(1));
        wait_idle("t6_idle");
        check("t6_done", {cfg_done, cfg_error}, 64'h2);
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
